// File: rtl/input_block_sequencer.sv
// rtl/input_block_sequencer.sv - Load-then-replay word buffer with a registered, one-cycle-latency read port.
module input_block_sequencer #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WRAP   = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic              next,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              last,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    logic full_w;
    logic write_w;
    logic read_w;
    logic at_end_w;

    assign full_w   = (count_q == DEPTH_C);
    assign write_w  = wr_en && !full_w && !clear;
    assign read_w   = next && (state_q == ST_READY) && !clear;
    // Uses the pre-edge count, so a same-cycle write never moves the end marker of this read.
    assign at_end_w = ({1'b0, rd_ptr_q} == (count_q - ONE_C));

    // Storage has no reset: contents survive both reset and clear.
    always_ff @(posedge clk) begin
        if (write_w) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;

        if (clear) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (read_w) begin
                data_d  = mem[rd_ptr_q];
                valid_d = 1'b1;
                last_d  = at_end_w;
                if (at_end_w && (WRAP != 0)) begin
                    rd_ptr_d = '0;
                end else begin
                    rd_ptr_d = rd_ptr_q + ONE_A;
                end
                if (at_end_w && (WRAP == 0)) begin
                    state_d = ST_DONE;
                end
            end
            if (write_w) begin
                wr_ptr_d = wr_ptr_q + ONE_A;
                count_d  = count_q + ONE_C;
                if (state_q == ST_EMPTY) begin
                    state_d = ST_READY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign last     = last_q;
    assign full     = full_w;
    assign count    = count_q;

endmodule

// File: doc/input_block_sequencer.md
INPUT_BLOCK_SEQUENCER -- requirements
Module: input_block_sequencer

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the word width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the word count, a power of two and at least 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), SHALL set the pointer width.
REQ-004 Parameter WRAP, default 1, SHALL select 1 = circular replay and 0 = single pass then stop.
REQ-005 Ports SHALL be as follows:
- clk  input  1  sole clock; all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe, appends wr_data.
- wr_data  input  DATA_W  word to append.
- clear  input  1  synchronous flush of pointers and state.
- next  input  1  request next stored word.
- data_out  output  DATA_W  registered read word.
- valid  output  1  one-cycle pulse, data_out updated.
- last  output  1  qualifies valid; word is final loaded entry.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  number of loaded words.

Function
REQ-006 Storage SHALL be DEPTH x DATA_W, written only through wr_en; contents SHALL be preserved by reset and clear.
REQ-007 wr_en=1 with full=0 SHALL write mem[wr_ptr] and increment wr_ptr and count in the same edge.
REQ-008 wr_en=1 with full=1 SHALL be ignored with no pointer, count or data change.
REQ-009 The FSM SHALL have three states:
- EMPTY: count==0.
- READY: count>0, accepting next.
- DONE: WRAP=0 pass finished.
REQ-010 The FSM SHALL go EMPTY->READY on the edge where the first write lands.
REQ-011 In EMPTY and DONE, next SHALL be ignored and valid SHALL stay 0.
REQ-012 next=1 in READY at edge N SHALL produce, after edge N, data_out=mem[rd_ptr], valid=1 and last=(rd_ptr==count-1), for one cycle (latency 1).
REQ-013 After an accepted next, rd_ptr SHALL increment; if it was count-1, WRAP=1 SHALL return rd_ptr to 0 and stay in READY, and WRAP=0 SHALL go to DONE.
REQ-014 next held high SHALL yield one valid word per cycle.
REQ-015 When valid=0, data_out SHALL hold its last value and last SHALL be 0.
REQ-016 For simultaneous wr_en and next, the read SHALL use the pre-edge count for last and wrap decisions, and the write SHALL take effect too.
REQ-017 A read of the entry being written in the same cycle SHALL be impossible, because rd_ptr < pre-edge count <= wr_ptr.
REQ-018 Writes in DONE SHALL be accepted and the state SHALL remain DONE.
REQ-019 clear=1 SHALL, at the next edge, zero wr_ptr, rd_ptr and count, set valid=0, last=0 and state EMPTY, with priority over wr_en and next that cycle.
REQ-020 full SHALL be a registered or direct decode of count==DEPTH, never asserted otherwise.
REQ-021 count arithmetic SHALL be unsigned, ADDR_W+1 bits, and SHALL never exceed DEPTH or underflow.

Reset
REQ-022 reset_L=0 SHALL immediately, without waiting for clk, force data_out=0, valid=0, last=0, full=0, count=0, wr_ptr=0, rd_ptr=0 and state EMPTY.
REQ-023 Reset asserted mid-stream SHALL abort the stream, with no valid pulse on the first edge after deassertion.
REQ-024 Release of reset_L SHALL need no clk synchronisation; the first active edge SHALL behave as from EMPTY.

Verification (DEPTH=4, DATA_W=128, WRAP=1 unless stated)
REQ-025 The bench SHALL cover:
- Write 0xA0..0xA3, then next 5 cycles -> data A0,A1,A2,A3,A0; last only with A3; full=1; count=4.
- WRAP=0, 2 words B0,B1, next 4 cycles -> valid on B0,B1 only; last with B1; then DONE, valid stays 0.
- next with count=0 -> valid=0, data_out=0; 5th write after full -> ignored, mem[0] unchanged.
- 2 words loaded, rd_ptr=1, wr_en(C2)+next same edge -> output word 1 with last=1, rd_ptr wraps to 0, count=3.
- clear plus wr_en plus next same edge -> count=0, valid=0, EMPTY; later reads return old mem after rewrite order.
- reset_L low mid-stream between edges -> outputs 0 at once; after release next with count 0 -> no valid.
